// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the RV32IMC single-cycle core.
// Define CSR_COUNTERS_EN to implement mcycle/minstret (64-bit) and mcountinhibit.
module csr_trap_unit #(
  parameter int          XLEN          = 32,
  parameter int          NUM_LOCAL_INT = 4,
  parameter logic [31:0] HART_ID       = 32'h0000_0000,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE    = 32'h4000_1104
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            instr_valid_i,
  input  logic                                            instr_retire_i,
  input  logic [2:0]                                      csr_op_i,
  input  logic [11:0]                                     csr_addr_i,
  input  logic [XLEN-1:0]                                 csr_src_i,
  input  logic                                            src_zero_i,
  input  logic                                            illegal_instr_i,
  input  logic                                            ecall_i,
  input  logic                                            ebreak_i,
  input  logic                                            mret_i,
  input  logic [31:0]                                     instr_bits_i,
  input  logic [XLEN-1:0]                                 pc_i,
  input  logic                                            ext_irq_i,
  input  logic                                            sw_irq_i,
  input  logic                                            timer_irq_i,
  input  logic [((NUM_LOCAL_INT > 0) ? NUM_LOCAL_INT : 1)-1:0] local_irq_i,
  output logic [XLEN-1:0]                                 csr_rdata_o,
  output logic                                            csr_illegal_o,
  output logic                                            trap_o,
  output logic [XLEN-1:0]                                 trap_pc_o,
  output logic                                            mret_o,
  output logic [XLEN-1:0]                                 mepc_o
);

  localparam logic [11:0] ADDR_MVENDORID = 12'hF11, ADDR_MARCHID = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13, ADDR_MHARTID = 12'hF14;
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300, ADDR_MISA    = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304, ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340, ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342, ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00, ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80, ADDR_MINSTRETH = 12'hB82;

  localparam logic [63:0] LOCAL_ONES = (64'd1 << NUM_LOCAL_INT) - 64'd1;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | {LOCAL_ONES[15:0], 16'h0000};

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic        sw_q, timer_q, ext_q;
  logic [15:0] local_q, local_ext;
  logic [31:0] mip, pend, rdata, csr_wdata;
  logic        impl, cs, wr_req, csr_we, illegal_any, irq_take, exc;
  logic [4:0]  irq_cause, exc_cause, trap_cause;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
  logic        cy_inh, ir_inh;
`else
  logic        unused_retire;
  assign unused_retire = instr_retire_i;
`endif

  always_comb begin
    local_ext = '0;
    for (int i = 0; i < NUM_LOCAL_INT; i++) local_ext[i] = local_irq_i[i];
  end

  always_comb begin
    mip        = '0;
    mip[3]     = sw_q;
    mip[7]     = timer_q;
    mip[11]    = ext_q;
    mip[31:16] = local_q;
  end

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (csr_addr_i)
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: rdata = '0;
      ADDR_MHARTID:  rdata = HART_ID;
      ADDR_MISA:     rdata = MISA_VALUE;
      ADDR_MSTATUS:  rdata = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      ADDR_MIE:      rdata = mie_q;
      ADDR_MIP:      rdata = mip;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MTVAL:    rdata = mtval_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCOUNTINHIBIT: rdata = {29'b0, ir_inh, 1'b0, cy_inh};
      ADDR_MCYCLE:    rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  rdata = minstret_q[31:0];
      ADDR_MINSTRETH: rdata = minstret_q[63:32];
`else
      ADDR_MCOUNTINHIBIT, ADDR_MCYCLE, ADDR_MCYCLEH,
      ADDR_MINSTRET, ADDR_MINSTRETH: rdata = '0;
`endif
      default: impl = 1'b0;
    endcase
  end

  // funct3[1:0]: 01 write, 10 set, 11 clear; set/clear with a zero source is a pure read.
  assign cs     = instr_valid_i & (csr_op_i != 3'b000);
  assign wr_req = cs & ((csr_op_i[1:0] == 2'b01) | (csr_op_i[1] & ~src_zero_i));

  always_comb begin
    case (csr_op_i[1:0])
      2'b01:   csr_wdata = csr_src_i;
      2'b10:   csr_wdata = rdata | csr_src_i;
      2'b11:   csr_wdata = rdata & ~csr_src_i;
      default: csr_wdata = rdata;
    endcase
  end

  assign csr_illegal_o = reset & cs & (~impl | (csr_op_i[1:0] == 2'b00) |
                                       (wr_req & (csr_addr_i[11:10] == 2'b11)));

  // Lowest local index is applied last so it wins among locals; standard sources override.
  always_comb begin
    pend      = mie_q & mip;
    irq_cause = 5'd0;
    for (int i = 15; i >= 0; i--) if (pend[16+i]) irq_cause = 5'(16 + i);
    if (pend[7])  irq_cause = 5'd7;
    if (pend[3])  irq_cause = 5'd3;
    if (pend[11]) irq_cause = 5'd11;
  end

  assign illegal_any = illegal_instr_i | csr_illegal_o;

  always_comb begin
    exc_cause = 5'd3;
    if (ecall_i)     exc_cause = 5'd11;
    if (illegal_any) exc_cause = 5'd2;
  end

  assign irq_take   = instr_valid_i & mst_mie & (pend != 32'h0);
  assign exc        = instr_valid_i & (illegal_any | ecall_i | ebreak_i);
  assign trap_o     = reset & (irq_take | exc);
  assign trap_cause = irq_take ? irq_cause : exc_cause;
  assign mret_o     = reset & mret_i & instr_valid_i & ~trap_o;
  assign csr_we     = wr_req & ~trap_o;
  assign mepc_o     = mepc_q;
  assign csr_rdata_o = rdata;

  always_comb begin
    trap_pc_o = {mtvec_q[31:2], 2'b00};
    if (irq_take && (mtvec_q[1:0] == 2'b01))
      trap_pc_o = {mtvec_q[31:2], 2'b00} + {25'b0, irq_cause, 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      sw_q       <= 1'b0;
      timer_q    <= 1'b0;
      ext_q      <= 1'b0;
      local_q    <= '0;
    end else begin
      sw_q    <= sw_irq_i;
      timer_q <= timer_irq_i;
      ext_q   <= ext_irq_i;
      local_q <= local_ext;
      if (trap_o) begin
        mepc_q   <= {pc_i[31:1], 1'b0};
        mcause_q <= {irq_take, 26'b0, trap_cause};
        mtval_q  <= (irq_take || exc_cause == 5'd11) ? 32'h0 :
                    (exc_cause == 5'd2) ? instr_bits_i : pc_i;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else begin
        if (csr_we) begin
          case (csr_addr_i)
            ADDR_MSTATUS: begin
              mst_mie  <= csr_wdata[3];
              mst_mpie <= csr_wdata[7];
            end
            ADDR_MIE:      mie_q      <= csr_wdata & MIE_MASK;
            ADDR_MTVEC:    mtvec_q    <= {csr_wdata[31:2], csr_wdata[1] ? mtvec_q[1:0] : csr_wdata[1:0]};
            ADDR_MSCRATCH: mscratch_q <= csr_wdata;
            ADDR_MEPC:     mepc_q     <= {csr_wdata[31:1], 1'b0};
            ADDR_MCAUSE:   mcause_q   <= csr_wdata;
            ADDR_MTVAL:    mtval_q    <= csr_wdata;
            default: ;
          endcase
        end
        if (mret_o) begin
          mst_mie  <= mst_mpie;
          mst_mpie <= 1'b1;
        end
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A CSR write replaces only the half it targets; the other half keeps the incremented value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      cy_inh     <= 1'b0;
      ir_inh     <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_q + {63'b0, ~cy_inh};
      minstret_q <= minstret_q + {63'b0, instr_retire_i & ~trap_o & ~ir_inh};
      if (csr_we) begin
        case (csr_addr_i)
          ADDR_MCOUNTINHIBIT: begin
            cy_inh <= csr_wdata[0];
            ir_inh <= csr_wdata[2];
          end
          ADDR_MCYCLE:    mcycle_q[31:0]    <= csr_wdata;
          ADDR_MCYCLEH:   mcycle_q[63:32]   <= csr_wdata;
          ADDR_MINSTRET:  minstret_q[31:0]  <= csr_wdata;
          ADDR_MINSTRETH: minstret_q[63:32] <= csr_wdata;
          default: ;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus random instructions,
// all compared cycle by cycle against an architectural model of the CSR/trap rules.
module tb_csr_trap_unit;

  localparam int          NLI       = 4;
  localparam logic [31:0] HART      = 32'h0000_0005;
  localparam logic [31:0] RST_MTVEC = 32'h0000_0100;
  localparam logic [31:0] MISA      = 32'h4000_1104;
  localparam logic [31:0] MIE_BITS  = 32'h000F_0888;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid, instr_retire, src_zero;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src, instr_bits, pc;
  logic        illegal_instr, ecall, ebreak, mret_in;
  logic        ext_irq = 1'b0, sw_irq = 1'b0, timer_irq = 1'b0;
  logic [NLI-1:0] local_irq = '0;
  logic [31:0] csr_rdata, trap_pc, mepc;
  logic        csr_illegal, trap, mret_out;

  csr_trap_unit #(
    .XLEN(32), .NUM_LOCAL_INT(NLI), .HART_ID(HART),
    .RESET_MTVEC(RST_MTVEC), .MISA_VALUE(MISA)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_valid_i(instr_valid), .instr_retire_i(instr_retire),
    .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_src_i(csr_src), .src_zero_i(src_zero),
    .illegal_instr_i(illegal_instr), .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret_in),
    .instr_bits_i(instr_bits), .pc_i(pc),
    .ext_irq_i(ext_irq), .sw_irq_i(sw_irq), .timer_irq_i(timer_irq), .local_irq_i(local_irq),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal), .trap_o(trap),
    .trap_pc_o(trap_pc), .mret_o(mret_out), .mepc_o(mepc)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (architectural state) ----------------
  bit          m_mie, m_mpie;
  logic [31:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_inhibit;
  logic [63:0] m_cycle, m_instret;
  logic [31:0] exp_q[$];

  // values observed in the most recent cycle, for directed checks
  logic [31:0] last_rdata, last_trap_pc, last_mepc;
  logic        last_trap, last_mret, last_illegal;

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0; m_tvec = RST_MTVEC;
    m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_inhibit = 0;
    m_cycle = 0; m_instret = 0;
    exp_q.delete();
  endtask

  function automatic void model_read(input logic [11:0] a, output logic [31:0] v, output bit ok);
    ok = 1;
    v  = 0;
    case (a)
      12'hF11, 12'hF12, 12'hF13: v = 0;
      12'hF14: v = HART;
      12'h301: v = MISA;
      12'h300: begin v = 32'h0000_1800; v[7] = m_mpie; v[3] = m_mie; end
      12'h304: v = m_ie;
      12'h344: v = m_ip;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
`ifdef CSR_COUNTERS_EN
      12'h320: v = m_inhibit;
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
`else
      12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82: v = 0;
`endif
      default: ok = 0;
    endcase
  endfunction

  // One instruction cycle: inputs already driven after a negedge.
  task automatic run_cycle();
    logic [31:0] old, newv, pend, tpc;
    bit ok, cs, wr, ill, irq, exc, tr, mr;
    int cause;
    #2;
    cs = instr_valid && (csr_op != 3'b000);
    model_read(csr_addr, old, ok);
    wr  = cs && ((csr_op[1:0] == 2'b01) || (csr_op[1] && !src_zero));
    ill = cs && (!ok || csr_op[1:0] == 2'b00 || (wr && csr_addr[11:10] == 2'b11));
    pend = m_ie & m_ip;
    irq = instr_valid && m_mie && (pend != 0);
    cause = 0;
    if (irq) begin
      if (pend[11]) cause = 11;
      else if (pend[3]) cause = 3;
      else if (pend[7]) cause = 7;
      else for (int i = NLI - 1; i >= 0; i--) if (pend[16+i]) cause = 16 + i;
    end
    exc = instr_valid && (illegal_instr || ill || ecall || ebreak);
    if (!irq && exc) cause = (illegal_instr || ill) ? 2 : (ecall ? 11 : 3);
    tr = irq || exc;
    mr = instr_valid && mret_in && !tr;
    tpc = {m_tvec[31:2], 2'b00};
    if (irq && m_tvec[1:0] == 2'b01) tpc = tpc + 32'(cause * 4);

    last_rdata = csr_rdata; last_trap = trap; last_trap_pc = trap_pc;
    last_mret = mret_out; last_mepc = mepc; last_illegal = csr_illegal;
    check("trap_o", trap, tr);
    check("mret_o", mret_out, mr);
    check("mepc_o", mepc, m_epc);
    check("csr_illegal_o", csr_illegal, ill);
    if (tr) check("trap_pc_o", trap_pc, tpc);
    if (cs && ok) begin
      exp_q.push_back(old);
      check("csr_rdata_o", csr_rdata, exp_q.pop_front());
    end

    case (csr_op[1:0])
      2'b01:   newv = csr_src;
      2'b10:   newv = old | csr_src;
      2'b11:   newv = old & ~csr_src;
      default: newv = old;
    endcase
`ifdef CSR_COUNTERS_EN
    if (!m_inhibit[0]) m_cycle = m_cycle + 1;
    if (instr_retire && !tr && !m_inhibit[2]) m_instret = m_instret + 1;
`endif
    if (tr) begin
      m_epc   = pc & 32'hFFFF_FFFE;
      m_cause = (irq ? 32'h8000_0000 : 32'h0) | 32'(cause);
      m_tval  = irq ? 32'h0 : (cause == 2) ? instr_bits : (cause == 3) ? pc : 32'h0;
      m_mpie  = m_mie;
      m_mie   = 0;
    end else begin
      if (wr && !ill) begin
        case (csr_addr)
          12'h300: begin m_mie = newv[3]; m_mpie = newv[7]; end
          12'h304: m_ie = newv & MIE_BITS;
          12'h305: m_tvec = (newv[1:0] >= 2) ? {newv[31:2], m_tvec[1:0]} : newv;
          12'h340: m_scratch = newv;
          12'h341: m_epc = newv & 32'hFFFF_FFFE;
          12'h342: m_cause = newv;
          12'h343: m_tval = newv;
`ifdef CSR_COUNTERS_EN
          12'h320: m_inhibit = newv & 32'h0000_0005;
          12'hB00: m_cycle[31:0] = newv;
          12'hB80: m_cycle[63:32] = newv;
          12'hB02: m_instret[31:0] = newv;
          12'hB82: m_instret[63:32] = newv;
`endif
          default: ;
        endcase
      end
      if (mr) begin m_mie = m_mpie; m_mpie = 1; end
    end
    m_ip = 0;
    m_ip[3] = sw_irq; m_ip[7] = timer_irq; m_ip[11] = ext_irq;
    for (int i = 0; i < NLI; i++) m_ip[16+i] = local_irq[i];
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  logic [31:0] next_pc = 32'h0000_1000;

  task automatic clear_inputs();
    instr_valid = 0; instr_retire = 0; csr_op = 0; csr_addr = 0; csr_src = 0;
    src_zero = 1; illegal_instr = 0; ecall = 0; ebreak = 0; mret_in = 0;
    instr_bits = 32'h0000_0013; pc = next_pc;
  endtask

  task automatic drive_instr(input logic [31:0] at_pc);
    clear_inputs();
    instr_valid = 1; instr_retire = 1; pc = at_pc;
  endtask

  task automatic drive_csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src);
    drive_instr(next_pc);
    next_pc = next_pc + 4;
    csr_op = op; csr_addr = addr; csr_src = src; src_zero = (src == 0);
  endtask

  task automatic csr_cycle(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src);
    drive_csr(op, addr, src);
    run_cycle();
  endtask

  task automatic expect_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_cycle(3'b010, addr, 32'h0);
    check(tag, last_rdata, exp);
  endtask

  task automatic idle_cycle();
    clear_inputs();
    run_cycle();
  endtask

  // ---------------- stimulus ----------------
  logic [11:0] addr_tab[18] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301,
                                12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82};

  initial begin
    clear_inputs();
    model_reset();

    // Reset held: even an excepting CSR access must not trap or fault.
    @(negedge clk);
    drive_csr(3'b001, 12'h7C0, 32'h1);
    ecall = 1; mret_in = 1;
    #2;
    check("rst_trap", trap, 1'b0);
    check("rst_mret", mret_out, 1'b0);
    check("rst_illegal", csr_illegal, 1'b0);
    @(negedge clk);
    clear_inputs();
    reset = 1;

    expect_csr("mstatus_reset", 12'h300, 32'h0000_1800);
    expect_csr("mtvec_reset", 12'h305, RST_MTVEC);
    expect_csr("mhartid", 12'hF14, HART);
    expect_csr("misa", 12'h301, MISA);

    // mtvec WARL mode
    csr_cycle(3'b001, 12'h305, 32'h8000_0001);
    expect_csr("mtvec_vec", 12'h305, 32'h8000_0001);
    csr_cycle(3'b001, 12'h305, 32'h9000_0003);
    expect_csr("mtvec_mode_kept", 12'h305, 32'h9000_0001);
    csr_cycle(3'b001, 12'h305, 32'h8000_0001);

    // Timer interrupt, vectored
    csr_cycle(3'b010, 12'h300, 32'h8);
    csr_cycle(3'b010, 12'h304, 32'h80);
    clear_inputs(); timer_irq = 1; run_cycle();
    timer_irq = 0;
    drive_instr(32'h0000_0200);
    run_cycle();
    check("tmr_trap", last_trap, 1'b1);
    check("tmr_trap_pc", last_trap_pc, 32'h8000_001C);
    expect_csr("tmr_mcause", 12'h342, 32'h8000_0007);
    expect_csr("tmr_mstatus", 12'h300, 32'h0000_1880);
    expect_csr("tmr_mepc", 12'h341, 32'h0000_0200);
    drive_instr(32'h0000_0300); mret_in = 1;
    run_cycle();
    check("mret_o", last_mret, 1'b1);
    check("mret_mepc", last_mepc, 32'h0000_0200);
    expect_csr("mret_mstatus", 12'h300, 32'h0000_1888);

    // Exceptions: illegal beats ecall; CSR write to read-only space; ebreak; ecall
    drive_instr(32'h0000_0400); illegal_instr = 1; ecall = 1; instr_bits = 32'hFFFF_FFFF;
    run_cycle();
    check("ill_trap", last_trap, 1'b1);
    check("ill_trap_pc", last_trap_pc, 32'h8000_0000);
    expect_csr("ill_mcause", 12'h342, 32'h0000_0002);
    expect_csr("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    drive_csr(3'b001, 12'hF11, 32'h1); instr_bits = 32'hF110_9073;
    run_cycle();
    check("ro_write_illegal", last_illegal, 1'b1);
    expect_csr("ro_mcause", 12'h342, 32'h0000_0002);
    expect_csr("ro_mtval", 12'h343, 32'hF110_9073);
    expect_csr("ro_read_ok", 12'hF11, 32'h0);
    drive_instr(32'h0000_0404); ebreak = 1;
    run_cycle();
    expect_csr("ebreak_mcause", 12'h342, 32'h0000_0003);
    expect_csr("ebreak_mtval", 12'h343, 32'h0000_0404);
    drive_instr(32'h0000_0408); ecall = 1;
    run_cycle();
    expect_csr("ecall_mcause", 12'h342, 32'h0000_000B);
    expect_csr("ecall_mtval", 12'h343, 32'h0);

    // Counters
`ifdef CSR_COUNTERS_EN
    csr_cycle(3'b001, 12'hB00, 32'hFFFF_FFFF);
    expect_csr("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    expect_csr("mcycleh_carry", 12'hB80, 32'h0000_0001);
    csr_cycle(3'b010, 12'h320, 32'h1);
    csr_cycle(3'b010, 12'hB00, 32'h0);
    csr_cycle(3'b010, 12'hB00, 32'h0);
    drive_instr(32'h0000_0500); ecall = 1;
    run_cycle();
    csr_cycle(3'b010, 12'hB02, 32'h0);
    csr_cycle(3'b011, 12'h320, 32'h1);
`else
    expect_csr("mcycle_absent", 12'hB00, 32'h0);
    drive_csr(3'b001, 12'hB00, 32'h1234);
    run_cycle();
    check("mcycle_write_ok", last_illegal, 1'b0);
    expect_csr("mcycle_still0", 12'hB00, 32'h0);
`endif

    // Local interrupts vs MTI priority
    csr_cycle(3'b010, 12'h304, 32'h0005_0000);
    csr_cycle(3'b010, 12'h300, 32'h8);
    clear_inputs(); timer_irq = 1; local_irq = 4'b0101; run_cycle();
    drive_instr(32'h0000_0600); run_cycle();
    check("prio_trap", last_trap, 1'b1);
    expect_csr("prio_mti", 12'h342, 32'h8000_0007);
    clear_inputs(); timer_irq = 0; run_cycle();
    csr_cycle(3'b010, 12'h300, 32'h8);
    drive_instr(32'h0000_0700); run_cycle();
    check("local_trap", last_trap, 1'b1);
    check("local_trap_pc", last_trap_pc, 32'h8000_0040);
    expect_csr("prio_local0", 12'h342, 32'h8000_0010);
    local_irq = 0;
    idle_cycle();

    // Reset in mid-instruction discards the pending write
    drive_csr(3'b001, 12'h340, 32'h1234_5678);
    #2;
    reset = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    reset = 1;
    expect_csr("midrst_mscratch", 12'h340, 32'h0);
    expect_csr("midrst_mcause", 12'h342, 32'h0);
    expect_csr("midrst_mtvec", 12'h305, RST_MTVEC);

    // Random instruction stream
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] op;
      clear_inputs();
      instr_valid  = ($urandom_range(0, 9) < 8);
      instr_retire = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      if (op == 3'b100 && $urandom_range(0, 3) != 0) op = 3'b000;
      csr_op   = op;
      csr_addr = ($urandom_range(0, 19) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 17)];
      if (op[2]) csr_src = 32'($urandom_range(0, 31));
      else begin
        case ($urandom_range(0, 3))
          0: csr_src = 32'h0;
          1: csr_src = $urandom;
          2: csr_src = 32'h0000_0088;
          default: csr_src = $urandom & MIE_BITS;
        endcase
      end
      src_zero      = (csr_src == 0);
      illegal_instr = ($urandom_range(0, 29) == 0);
      ecall         = ($urandom_range(0, 29) == 0);
      ebreak        = ($urandom_range(0, 29) == 0);
      mret_in       = ($urandom_range(0, 19) == 0);
      instr_bits    = $urandom;
      pc            = $urandom & 32'hFFFF_FFFE;
      sw_irq        = ($urandom_range(0, 9) == 0);
      timer_irq     = ($urandom_range(0, 9) == 0);
      ext_irq       = ($urandom_range(0, 15) == 0);
      local_irq     = ($urandom_range(0, 3) == 0) ? NLI'($urandom) : '0;
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR and trap controller for the RV32IMC single-cycle core.
- Sits beside the decoder and writeback. It performs Zicsr read-modify-write and prioritises interrupts and exceptions.
- Supplies the trap target and mret return PC to PC-select.
- Successor block: configurable local-interrupt count, hart ID, reset mtvec and misa; WARL masking; vectored mode; mtval capture; 64-bit counters.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NUM_LOCAL_INT, 4, platform interrupts mapped to mip/mie bits 16..16+N-1; range 0..16.
- HART_ID, 0, constant read from mhartid.
- RESET_MTVEC, 32'h0000_0000, mtvec value at reset.
- MISA_VALUE, 32'h4000_1104, read-only misa value (RV32IMC).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- instr_valid_i  in  1  an instruction is executing this cycle
- instr_retire_i  in  1  the instruction completes (used for minstret)
- csr_op_i  in  3  funct3; 000 means not a CSR operation
- csr_addr_i  in  12  CSR address
- csr_src_i  in  XLEN  rs1 value, or zero-extended zimm when csr_op_i[2]=1
- src_zero_i  in  1  rs1 index or zimm equals 0
- illegal_instr_i, ecall_i, ebreak_i, mret_i  in  1 each  decoder exception and return flags
- instr_bits_i  in  32  raw instruction word, captured into mtval
- pc_i  in  XLEN  PC of the current instruction
- ext_irq_i, sw_irq_i, timer_irq_i  in  1 each  standard machine interrupts
- local_irq_i  in  NUM_LOCAL_INT  platform interrupts
- csr_rdata_o  out  XLEN  old CSR value, sent to rd
- csr_illegal_o  out  1  CSR access fault
- trap_o  out  1  take trap this cycle
- trap_pc_o  out  XLEN  trap target address
- mret_o  out  1  mret executes this cycle
- mepc_o  out  XLEN  return address

Behaviour:
- Reset (reset=0, asynchronous):
  - All CSRs clear to 0, except mstatus.MPP=2'b11 and mtvec=RESET_MTVEC.
  - Interrupt synchroniser flops clear to 0.
  - trap_o=0, mret_o=0, csr_illegal_o=0.
  - Reset asserted mid-instruction discards the pending write or trap.
- Outputs are combinational from the current inputs and state. State updates at posedge clk. Zero-cycle read, one-cycle write.
- CSR access:
  - cs = instr_valid_i & (csr_op_i!=0).
  - Read returns the old value. For unimplemented addresses, csr_illegal_o=1.
  - New value by op: RW/RWI → src; RS/RSI → old|src; RC/RCI → old&~src.
  - RS/RC/RSI/RCI with src_zero_i=1 do not write.
  - A write to a read-only address (addr[11:10]==2'b11) raises csr_illegal_o. Reads of that address still succeed.
- Implemented CSRs:
  - mvendorid=0, marchid=0, mimpid=0, mhartid=HART_ID, misa=MISA_VALUE.
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP is hardwired 11.
  - mie: writable bits are 3, 7, 11 and 16+i.
  - mip: read-only, from flopped inputs.
  - mtvec: a write with MODE (bits [1:0]) of 2 or 3 keeps the old MODE; BASE is always written.
  - mscratch.
  - mepc: bit 0 is forced to 0.
  - mcause, mtval.
  - mcycle/mcycleh, minstret/minstreth.
  - mcountinhibit: only bits CY[0] and IR[2] are writable.
- Interrupt inputs are registered once into mip before use.
- Trap selection (only when instr_valid_i=1):
  - An interrupt is pending when mstatus.MIE & (mie&mip)!=0.
  - Interrupt priority: MEI(11) > MSI(3) > MTI(7) > local 16+i, with lower i winning.
  - Otherwise the exception priority is: illegal (illegal_instr_i | csr_illegal_o, cause 2) > ecall (11) > ebreak (3).
  - trap_o = interrupt | exception.
- Trap commit (edge with trap_o=1):
  - mepc ← pc_i.
  - mcause ← {interrupt, cause}.
  - mtval ← instr_bits_i for illegal, pc_i for ebreak, otherwise 0.
  - MPIE ← MIE, MIE ← 0.
  - The instruction's own CSR write is suppressed. minstret does not increment.
- trap_pc_o:
  - MODE=0: {BASE,2'b00}.
  - MODE=1 with an interrupt: {BASE,2'b00} + 4*cause.
  - Exceptions always go to {BASE,2'b00}.
- mret:
  - mret_o = mret_i & instr_valid_i & ~trap_o.
  - On the edge: MIE ← MPIE, MPIE ← 1.
  - mepc_o = mepc at all times.
- Simultaneous events:
  - A trap beats mret.
  - A trap beats the CSR write.
  - A CSR write to mstatus/mepc/mcause in a non-trapping cycle takes effect the next cycle. A pending interrupt newly enabled that way is taken on the following instruction.
- Counters (64-bit, carry from low to high word):
  - mcycle increments every cycle unless CY is set.
  - minstret increments on instr_retire_i & ~trap_o unless IR is set.
  - A CSR write to either half wins over the increment in that cycle; the other half still counts.
  - Wrap from all-ones to 0 is silent.

Optional Feature:
- Macro CSR_COUNTERS_EN.
  - Defined: counters and mcountinhibit are implemented as above.
  - Undefined: the counter addresses read 0, writes are ignored without fault, and no counter flops exist.

Test Plan:
- Reset release → mstatus reads 32'h0000_1800, mtvec reads RESET_MTVEC, trap_o=0, mhartid=HART_ID.
- csrrw mtvec 0x8000_0001 → reads 0x8000_0001. Then csrrw mtvec 0x9000_0003 → reads 0x9000_0001 (MODE kept).
- Set MIE and mie[7], pulse timer_irq_i:
  - Two cycles later trap_o=1, mcause=0x8000_0007, trap_pc_o=0x8000_001C.
  - MIE=0, MPIE=1, mepc=pc_i.
  - A following mret restores MIE=1, and mret_o=1 with mepc_o=saved pc.
- illegal_instr_i with ecall_i together, instr_bits_i=0xFFFF_FFFF → mcause=2, mtval=0xFFFF_FFFF. A csrw to mvendorid → csr_illegal_o=1, mcause=2.
- mcycle written to 0xFFFF_FFFF → next cycle mcycle=0, mcycleh=1. Set CY → mcycle frozen. Retire with trap → minstret unchanged.
- Local interrupts 0 and 2 plus MTI all pending and enabled → mcause=0x8000_0007. With MTI removed → mcause=0x8000_0010.
